// File: rtl/writeback_queue_if.sv
// Bundle of the write-back stage's producer, register-file and decode-side signals.
// The slave modport is the queue itself; the master modport is whoever drives it.
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                       aluValid;
    logic                       aluReady;
    logic [ADDR_W-1:0]          aluAddr;
    logic [DATA_W-1:0]          aluData;
    logic                       memValid;
    logic [ADDR_W-1:0]          memAddr;
    logic [DATA_W-1:0]          memData;
    logic                       writeEnable;
    logic [ADDR_W-1:0]          writeAddr;
    logic [DATA_W-1:0]          writeData;
    logic [ADDR_W-1:0]          readAddr1;
    logic [ADDR_W-1:0]          readAddr2;
    logic                       pending1;
    logic                       pending2;
    logic [$clog2(DEPTH):0]     count;
    logic                       dropped;

    modport slave (
        input  aluValid, aluAddr, aluData,
        input  memValid, memAddr, memData,
        input  readAddr1, readAddr2,
        output aluReady, writeEnable, writeAddr, writeData,
        output pending1, pending2, count, dropped
    );

    modport master (
        output aluValid, aluAddr, aluData,
        output memValid, memAddr, memData,
        output readAddr1, readAddr2,
        input  aluReady, writeEnable, writeAddr, writeData,
        input  pending1, pending2, count, dropped
    );
endinterface

// File: rtl/writeback_queue.sv
// Register-file write-back arbiter: loads always win, ALU results bypass when idle
// or wait in an in-order FIFO; pending flags cover FIFO contents and the output stage.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_WRITABLE = ADDR_W'(8);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              dropped_reg, dropped_next;

    logic alu_ready, alu_fire, mem_ok, alu_ok, fifo_empty;
    logic enq, deq, bypass;

    always_comb begin
        alu_ready    = rst_n & (count_reg < CNT_W'(DEPTH));
        alu_fire     = bus.aluValid & alu_ready;
        mem_ok       = bus.memValid & (bus.memAddr <= LAST_WRITABLE);
        alu_ok       = alu_fire & (bus.aluAddr <= LAST_WRITABLE);
        fifo_empty   = (count_reg == '0);
        dropped_next = (bus.memValid & (bus.memAddr > LAST_WRITABLE))
                     | (alu_fire & (bus.aluAddr > LAST_WRITABLE));

        // Priority: load, then FIFO head, then direct ALU bypass.
        deq    = !mem_ok & !fifo_empty;
        bypass = !mem_ok & fifo_empty & alu_ok;
        enq    = alu_ok & !bypass;

        we_next   = 1'b0;
        addr_next = '0;
        data_next = '0;
        if (mem_ok) begin
            we_next   = 1'b1;
            addr_next = bus.memAddr;
            data_next = bus.memData;
        end else if (deq) begin
            we_next   = 1'b1;
            addr_next = addr_mem[rd_ptr_reg];
            data_next = data_mem[rd_ptr_reg];
        end else if (bypass) begin
            we_next   = 1'b1;
            addr_next = bus.aluAddr;
            data_next = bus.aluData;
        end

        count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            dropped_reg <= 1'b0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg   <= count_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            dropped_reg <= dropped_next;
        end
    end

    // Storage needs no reset: validity is derived from the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= bus.aluAddr;
            data_mem[wr_ptr_reg] <= bus.aluData;
        end
    end

    logic [DEPTH-1:0] match1, match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            logic             valid;
            assign offset     = PTR_W'(gi) - rd_ptr_reg;
            assign valid      = ({1'b0, offset} < count_reg);
            assign match1[gi] = valid & (addr_mem[gi] == bus.readAddr1);
            assign match2[gi] = valid & (addr_mem[gi] == bus.readAddr2);
        end
    endgenerate

    assign bus.aluReady    = alu_ready;
    assign bus.writeEnable = we_reg;
    assign bus.writeAddr   = addr_reg;
    assign bus.writeData   = data_reg;
    assign bus.count       = count_reg;
    assign bus.dropped     = dropped_reg;
    assign bus.pending1    = (bus.readAddr1 <= LAST_WRITABLE)
                           & ((|match1) | (we_reg & (addr_reg == bus.readAddr1)));
    assign bus.pending2    = (bus.readAddr2 <= LAST_WRITABLE)
                           & ((|match2) | (we_reg & (addr_reg == bus.readAddr2)));
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-back stage sitting in front of the CPU register file's single write port. Merges results from two producers, the ALU and the memory-load path, into one registered write per cycle. Buffers ALU results in a small in-order FIFO when the port is contended. Reports per-read-port "pending write" flags so decode can stall on in-flight results.

## Interface
- DEPTH, 4: ALU result FIFO entries (power of two, ≥2)
- ADDR_W, 4: register address width
- DATA_W, 32: register data width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- aluValid  in  1  ALU result offered
- aluReady  out  1  ALU result accepted when aluValid & aluReady at rising edge
- aluAddr  in  ADDR_W  ALU destination register
- aluData  in  DATA_W  ALU result
- memValid  in  1  load result; always accepted, no backpressure
- memAddr  in  ADDR_W  load destination register
- memData  in  DATA_W  load data
- writeEnable  out  1  register file write strobe (registered)
- writeAddr  out  ADDR_W  register file write address (registered)
- writeData  out  DATA_W  register file write data (registered)
- readAddr1, readAddr2  in  ADDR_W  decode-stage read addresses
- pending1, pending2  out  1  a write to readAddrN is queued or in the output stage (combinational)
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- dropped  out  1  one-cycle pulse: an accepted write targeted an unwritable address

## Operation
- Writable registers: addresses 0–8. Address 9 (PC+8 view) and 10–15 are unwritable. Such writes are accepted (handshake completes, mem consumed) but discarded: never enqueued, never output. dropped=1 the following cycle (single pulse even if both sources drop together).
- Output stage: one register {writeEnable, writeAddr, writeData}, reloaded every cycle. writeEnable=0 when nothing is selected.
- Selection each cycle, highest first:
  - valid writable memValid
  - FIFO head (dequeued)
  - accepted writable ALU result when FIFO empty (bypass, not enqueued)
- Accepted writable ALU results not bypassed are enqueued at the FIFO tail. ALU results always retire in acceptance order.
- aluReady = rst_n & (count < DEPTH). When full, ALU is refused even if a dequeue happens the same cycle.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo DEPTH.
- Same-register ordering between mem and ALU is the hazard unit's responsibility. The block only guarantees mem never waits and ALU order is preserved.
- pendingN=1 iff readAddrN ≤ 8 and it matches a valid FIFO entry or the output stage with writeEnable=1. Address 9 is never pending.

## Timing
- Reset (async assert, sync-safe deassert): writeEnable=0, writeAddr=0, writeData=0, count=0, dropped=0, FIFO empty, aluReady=0 while rst_n=0, pending1/2=0.
- Reset mid-operation: all queued and output-stage writes are lost. No write strobe is emitted during or after reset until new input arrives.
- Latency:
  - mem or bypassed ALU result appears on write port 1 cycle after acceptance; register file updated at the following edge
  - queued ALU result: 1 cycle after reaching head with memValid low
- Throughput: one register file write per cycle max. Sustained memValid starves the FIFO indefinitely (by design).
- count updates on the edge of enqueue/dequeue. aluReady reflects the new count the same cycle.

## Test plan
- Reset then idle: rst_n low 3 cycles with aluValid=1 -> aluReady=0, writeEnable=0, count=0. After release, aluReady=1 and no spurious write.
- ALU bypass: aluValid addr=3 data=0x11 at cycle t, FIFO empty, memValid=0 -> writeEnable=1 addr=3 data=0x11 at t+1; count stays 0.
- Contention and order: cycles t..t+4 memValid addr=1 plus aluValid addrs 2,3,4,5,6 -> four ALU accepted, count reaches 4, aluReady=0 at t+4. After memValid drops, writes retire 2,3,4,5, then 6 once accepted.
- Full + simultaneous: FIFO full, memValid=0, aluValid=1 -> that cycle ALU refused, head dequeued, count=3. Next cycle ALU accepted with dequeue, count stays 3.
- Unwritable address: memValid addr=9 data=0xDEAD -> no write strobe, dropped=1 for exactly one cycle. aluValid addr=12 -> handshake completes, count unchanged, dropped pulse.
- Pending flags: enqueue writes to r5 and r7, readAddr1=5, readAddr2=9 -> pending1=1, pending2=0. pending1 clears the cycle after r5 leaves the output stage.
